// File: rtl/region_plot_engine_pkg.sv
// Shared definitions for the region plot engine: job modes and FSM state encodings.
package region_plot_engine_pkg;

    localparam logic [1:0] MODE_FILL        = 2'd0;
    localparam logic [1:0] MODE_SHADE       = 2'd1;
    localparam logic [1:0] MODE_TRANSPARENT = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAW  = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/region_plot_engine_grid_counter.sv
// Raster x/y counter: x steps first, wraps at x_range and bumps y; last flags the final coordinate.
module region_plot_engine_grid_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             enable,
    input  logic [WIDTH-1:0] x_range,
    input  logic [WIDTH-1:0] y_range,
    output logic [WIDTH-1:0] xcnt,
    output logic [WIDTH-1:0] ycnt,
    output logic             last
);

    assign last = (xcnt == x_range) && (ycnt == y_range);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            xcnt <= '0;
            ycnt <= '0;
        end else if (enable) begin
            if (xcnt == x_range) begin
                xcnt <= '0;
                ycnt <= ycnt + 1'b1;
            end else begin
                xcnt <= xcnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/region_plot_engine.sv
// Round-robin multi-client rectangle scanner feeding a plot port with back-pressure.
//  state   | meaning
//  S_IDLE  | no job; arbitrate pending requests from rr_ptr upward
//  S_DRAW  | scanning granted rectangle, one coordinate per accepted cycle
//  S_FLUSH | last pixel issued; wait for sink to take it, then pulse done
module region_plot_engine
    import region_plot_engine_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int COLOUR_WIDTH = 3,
    parameter int NUM_CLIENTS  = 2,
    parameter int IDX_W        = 1
) (
    input  logic                            clock,
    input  logic                            resetn,
    input  logic [NUM_CLIENTS-1:0]          req,
    input  logic [2*NUM_CLIENTS-1:0]        req_mode,
    input  logic [WIDTH*NUM_CLIENTS-1:0]    req_x_min,
    input  logic [WIDTH*NUM_CLIENTS-1:0]    req_y_min,
    input  logic [WIDTH*NUM_CLIENTS-1:0]    req_x_range,
    input  logic [WIDTH*NUM_CLIENTS-1:0]    req_y_range,
    input  logic [COLOUR_WIDTH*NUM_CLIENTS-1:0] req_colour,
    input  logic [COLOUR_WIDTH-1:0]         shade_colour,
    output logic [NUM_CLIENTS-1:0]          grant,
    output logic [WIDTH-1:0]                scan_x,
    output logic [WIDTH-1:0]                scan_y,
    output logic [NUM_CLIENTS-1:0]          done,
    output logic                            busy,
    output logic                            plot,
    output logic [WIDTH-1:0]                plot_x,
    output logic [WIDTH-1:0]                plot_y,
    output logic [COLOUR_WIDTH-1:0]         plot_colour,
    input  logic                            plot_ready
);

    state_t                  state;
    logic [IDX_W-1:0]        rr_ptr;
    logic [IDX_W-1:0]        win_idx;
    logic [IDX_W-1:0]        cand;
    logic                    win_found;
    logic [1:0]              mode_q;
    logic [WIDTH-1:0]        x_min_q, y_min_q, x_range_q, y_range_q;
    logic [COLOUR_WIDTH-1:0] colour_q;
    logic [WIDTH-1:0]        xcnt, ycnt;
    logic                    last;
    logic                    adv;
    logic [WIDTH:0]          x_sum, y_sum;
    logic                    suppress;
    logic [COLOUR_WIDTH-1:0] pix_colour;

    logic [1:0]              mode_arr   [NUM_CLIENTS];
    logic [WIDTH-1:0]        x_min_arr  [NUM_CLIENTS];
    logic [WIDTH-1:0]        y_min_arr  [NUM_CLIENTS];
    logic [WIDTH-1:0]        x_rng_arr  [NUM_CLIENTS];
    logic [WIDTH-1:0]        y_rng_arr  [NUM_CLIENTS];
    logic [COLOUR_WIDTH-1:0] colour_arr [NUM_CLIENTS];

    for (genvar g = 0; g < NUM_CLIENTS; g++) begin : g_unpack
        assign mode_arr[g]   = req_mode[2*g +: 2];
        assign x_min_arr[g]  = req_x_min[WIDTH*g +: WIDTH];
        assign y_min_arr[g]  = req_y_min[WIDTH*g +: WIDTH];
        assign x_rng_arr[g]  = req_x_range[WIDTH*g +: WIDTH];
        assign y_rng_arr[g]  = req_y_range[WIDTH*g +: WIDTH];
        assign colour_arr[g] = req_colour[COLOUR_WIDTH*g +: COLOUR_WIDTH];
    end

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            cand = IDX_W'((int'(rr_ptr) + i) % NUM_CLIENTS);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Counters sit at zero whenever no scan is running, so each job starts from the origin.
    region_plot_engine_grid_counter #(.WIDTH(WIDTH)) u_grid (
        .clock   (clock),
        .resetn  (resetn && (state == S_DRAW)),
        .enable  (adv && (state == S_DRAW)),
        .x_range (x_range_q),
        .y_range (y_range_q),
        .xcnt    (xcnt),
        .ycnt    (ycnt),
        .last    (last)
    );

    assign adv    = !plot || plot_ready;
    assign busy   = (state != S_IDLE);
    assign x_sum  = {1'b0, x_min_q} + {1'b0, xcnt};
    assign y_sum  = {1'b0, y_min_q} + {1'b0, ycnt};
    assign scan_x = x_sum[WIDTH-1:0];
    assign scan_y = y_sum[WIDTH-1:0];

    // Carry out of either coordinate means the pixel fell off the screen edge.
    always_comb begin
        pix_colour = colour_q;
        suppress   = x_sum[WIDTH] | y_sum[WIDTH];
        case (mode_q)
            MODE_SHADE: pix_colour = shade_colour;
            MODE_TRANSPARENT: begin
                pix_colour = shade_colour;
                if (shade_colour == '0) suppress = 1'b1;
            end
            default: pix_colour = colour_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state       <= S_IDLE;
            rr_ptr      <= '0;
            grant       <= '0;
            done        <= '0;
            plot        <= 1'b0;
            plot_x      <= '0;
            plot_y      <= '0;
            plot_colour <= '0;
            mode_q      <= MODE_FILL;
            x_min_q     <= '0;
            y_min_q     <= '0;
            x_range_q   <= '0;
            y_range_q   <= '0;
            colour_q    <= '0;
        end else begin
            done <= '0;
            case (state)
                S_IDLE: begin
                    plot <= 1'b0;
                    if (win_found) begin
                        state     <= S_DRAW;
                        grant     <= NUM_CLIENTS'(1) << win_idx;
                        mode_q    <= mode_arr[win_idx];
                        x_min_q   <= x_min_arr[win_idx];
                        y_min_q   <= y_min_arr[win_idx];
                        x_range_q <= x_rng_arr[win_idx];
                        y_range_q <= y_rng_arr[win_idx];
                        colour_q  <= colour_arr[win_idx];
                        rr_ptr    <= (win_idx == IDX_W'(NUM_CLIENTS - 1)) ? '0 : win_idx + 1'b1;
                    end
                end
                S_DRAW: begin
                    if (adv) begin
                        plot        <= !suppress;
                        plot_x      <= scan_x;
                        plot_y      <= scan_y;
                        plot_colour <= pix_colour;
                        if (last) state <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (adv) begin
                        plot  <= 1'b0;
                        done  <= grant;
                        grant <= '0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_region_plot_engine.sv
// Scoreboard bench for region_plot_engine: directed jobs push expected pixels/dones, a monitor pops them.
module tb_region_plot_engine;
    import region_plot_engine_pkg::*;

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
        logic [2:0] c;
    } pix_t;

    logic        clock;
    logic        resetn;
    logic [1:0]  req;
    logic [3:0]  req_mode;
    logic [15:0] req_x_min, req_y_min, req_x_range, req_y_range;
    logic [5:0]  req_colour;
    logic [2:0]  shade_colour;
    logic [1:0]  grant;
    logic [7:0]  scan_x, scan_y;
    logic [1:0]  done;
    logic        busy;
    logic        plot;
    logic [7:0]  plot_x, plot_y;
    logic [2:0]  plot_colour;
    logic        plot_ready;

    int          shade_sel;
    int          n_pass;
    int          n_total;
    int          m;
    logic        found;
    pix_t        exp_pix[$];
    logic [1:0]  exp_done[$];

    region_plot_engine #(.WIDTH(8), .COLOUR_WIDTH(3), .NUM_CLIENTS(2), .IDX_W(1)) dut (
        .clock(clock), .resetn(resetn), .req(req), .req_mode(req_mode),
        .req_x_min(req_x_min), .req_y_min(req_y_min),
        .req_x_range(req_x_range), .req_y_range(req_y_range),
        .req_colour(req_colour), .shade_colour(shade_colour),
        .grant(grant), .scan_x(scan_x), .scan_y(scan_y), .done(done), .busy(busy),
        .plot(plot), .plot_x(plot_x), .plot_y(plot_y), .plot_colour(plot_colour),
        .plot_ready(plot_ready)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Shade source modelled as a draw unit colouring from the current scan coordinate.
    always_comb begin
        case (shade_sel)
            1:       shade_colour = scan_x[2:0];
            2:       shade_colour = scan_x[0] ? 3'd0 : scan_x[2:0];
            default: shade_colour = 3'd0;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    always @(negedge clock) begin
        if (plot && plot_ready) begin
            if (exp_pix.size() == 0) begin
                n_total++;
                $display("FAIL pix_extra: got pixel (%0d,%0d) expected none", plot_x, plot_y);
            end else begin
                pix_t e;
                e = exp_pix.pop_front();
                check("pix_x", plot_x, e.x);
                check("pix_y", plot_y, e.y);
                check("pix_colour", plot_colour, e.c);
            end
        end
        if (done != 2'b00) begin
            if (exp_done.size() == 0) begin
                n_total++;
                $display("FAIL done_extra: got done %b expected none", done);
            end else begin
                check("done_owner", done, exp_done.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic set_client(input int i, input logic [1:0] md, input logic [7:0] xm,
                              input logic [7:0] ym, input logic [7:0] xr, input logic [7:0] yr,
                              input logic [2:0] c);
        req_mode[2*i +: 2]    = md;
        req_x_min[8*i +: 8]   = xm;
        req_y_min[8*i +: 8]   = ym;
        req_x_range[8*i +: 8] = xr;
        req_y_range[8*i +: 8] = yr;
        req_colour[3*i +: 3]  = c;
    endtask

    task automatic push_pix(input logic [7:0] x, input logic [7:0] y, input logic [2:0] c);
        pix_t p;
        p.x = x; p.y = y; p.c = c;
        exp_pix.push_back(p);
    endtask

    task automatic wait_done(input int c, input int budget, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!done[c] && n < budget);
        check("done_seen", done[c], 1);
        req[c] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before 100us");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_pass = 0; n_total = 0; shade_sel = 0;
        resetn = 1'b0; req = 2'b00; plot_ready = 1'b1;
        req_mode = '0; req_x_min = '0; req_y_min = '0;
        req_x_range = '0; req_y_range = '0; req_colour = '0;
        repeat (3) tick();
        check("rst_grant", grant, 0);
        check("rst_busy", busy, 0);
        check("rst_plot", plot, 0);
        check("rst_done", done, 0);
        check("rst_plot_x", plot_x, 0);
        check("rst_plot_colour", plot_colour, 0);
        resetn = 1'b1;
        tick();

        // Single FILL job, latency and done timing.
        set_client(0, MODE_FILL, 8'd10, 8'd20, 8'd2, 8'd1, 3'd5);
        push_pix(10, 20, 5); push_pix(11, 20, 5); push_pix(12, 20, 5);
        push_pix(10, 21, 5); push_pix(11, 21, 5); push_pix(12, 21, 5);
        exp_done.push_back(2'b01);
        req[0] = 1'b1;
        tick();
        check("t1_grant", grant, 2'b01);
        check("t1_busy", busy, 1);
        tick();
        check("t1_first_plot", plot, 1);
        check("t1_first_x", plot_x, 10);
        wait_done(0, 40, m);
        check("t1_done_cycle", 2 + m, 8);
        tick();
        check("t1_idle_busy", busy, 0);

        resetn = 1'b0; tick(); resetn = 1'b1; tick();

        // Simultaneous requests, then client 0 re-requests: order 0,1,0.
        set_client(0, MODE_FILL, 8'd1, 8'd1, 8'd1, 8'd0, 3'd3);
        set_client(1, MODE_FILL, 8'd50, 8'd60, 8'd0, 8'd1, 3'd6);
        push_pix(1, 1, 3); push_pix(2, 1, 3);
        push_pix(50, 60, 6); push_pix(50, 61, 6);
        push_pix(30, 40, 2);
        exp_done.push_back(2'b01); exp_done.push_back(2'b10); exp_done.push_back(2'b01);
        req = 2'b11;
        tick();
        check("t2_grant_first", grant, 2'b01);
        wait_done(0, 40, m);
        set_client(0, MODE_FILL, 8'd30, 8'd40, 8'd0, 8'd0, 3'd2);
        req[0] = 1'b1;
        tick();
        check("t2_grant_second", grant, 2'b10);
        wait_done(1, 40, m);
        wait_done(0, 40, m);

        // SHADE with a 3-cycle stall while pixel (4,7) is presented.
        shade_sel = 1;
        set_client(0, MODE_SHADE, 8'd3, 8'd7, 8'd3, 8'd1, 3'd0);
        push_pix(3, 7, 3); push_pix(4, 7, 4); push_pix(5, 7, 5); push_pix(6, 7, 6);
        push_pix(3, 8, 3); push_pix(4, 8, 4); push_pix(5, 8, 5); push_pix(6, 8, 6);
        exp_done.push_back(2'b01);
        req[0] = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            tick();
            if (plot && plot_x == 8'd4) found = 1'b1;
        end
        check("t3_reach_stall", found, 1);
        plot_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t3_hold_plot", plot, 1);
            check("t3_hold_x", plot_x, 4);
            check("t3_hold_y", plot_y, 7);
            check("t3_hold_colour", plot_colour, 4);
            check("t3_hold_scan_x", scan_x, 5);
        end
        plot_ready = 1'b1;
        wait_done(0, 40, m);
        tick();

        // TRANSPARENT: zero shade on odd x suppresses those pixels.
        shade_sel = 2;
        set_client(1, MODE_TRANSPARENT, 8'd4, 8'd9, 8'd3, 8'd0, 3'd0);
        push_pix(4, 9, 4); push_pix(6, 9, 6);
        exp_done.push_back(2'b10);
        req[1] = 1'b1;
        wait_done(1, 40, m);
        check("t4_done_cycle", m, 6);
        shade_sel = 0;
        tick();

        // Clipping at the right edge.
        set_client(0, MODE_FILL, 8'd254, 8'd0, 8'd3, 8'd0, 3'd7);
        push_pix(254, 0, 7); push_pix(255, 0, 7);
        exp_done.push_back(2'b01);
        req[0] = 1'b1;
        tick();
        check("t5_scan_x0", scan_x, 254);
        tick();
        check("t5_plot_x0", plot_x, 254);
        tick();
        check("t5_scan_wrap", scan_x, 0);
        check("t5_plot_x1", plot_x, 255);
        tick();
        check("t5_clip_plot", plot, 0);
        check("t5_scan_x3", scan_x, 1);
        tick();
        check("t5_clip_plot_last", plot, 0);
        check("t5_plot_x_wrapped", plot_x, 1);
        wait_done(0, 10, m);
        check("t5_done_cycle", m, 1);
        tick();

        // Reset mid-job, then arbitration restarts from client 0.
        set_client(0, MODE_FILL, 8'd0, 8'd0, 8'd7, 8'd7, 3'd2);
        push_pix(0, 0, 2); push_pix(1, 0, 2); push_pix(2, 0, 2);
        req[0] = 1'b1;
        repeat (4) tick();
        check("t6_pre_rst_x", plot_x, 2);
        resetn = 1'b0;
        req = 2'b00;
        tick();
        check("t6_rst_plot", plot, 0);
        check("t6_rst_grant", grant, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_done", done, 0);
        resetn = 1'b1;
        repeat (3) tick();
        set_client(0, MODE_FILL, 8'd100, 8'd100, 8'd0, 8'd0, 3'd1);
        set_client(1, MODE_FILL, 8'd200, 8'd5, 8'd1, 8'd0, 3'd4);
        push_pix(100, 100, 1); push_pix(200, 5, 4); push_pix(201, 5, 4);
        exp_done.push_back(2'b01); exp_done.push_back(2'b10);
        req = 2'b11;
        tick();
        check("t6_grant_after_rst", grant, 2'b01);
        wait_done(0, 40, m);
        wait_done(1, 40, m);

        repeat (3) tick();
        check("end_pix_queue", exp_pix.size(), 0);
        check("end_done_queue", exp_done.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
